bank_arbiter: RTL and testbench

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_pkg.sv | 27 ++
 rtl/bank_arbiter_if.sv | 10 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/bank_arbiter.sv | 117 +++++++++++
 tb/tb_bank_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_pkg.sv
// Shared defaults and the round-robin pick helper for the bank arbiter.
package bank_pkg;

   localparam int unsigned ADDR_W_DEF = 7;
   localparam int unsigned DATA_W_DEF = 128;
   localparam int unsigned MAX_REQ    = 4;

   // One-hot grant for the first set request at or after ptr, scanning n requesters.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input int unsigned ptr,
                                                  input int unsigned n);
      logic [MAX_REQ-1:0] gnt;
      logic               found;
      logic [1:0]         idx;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = 2'((ptr + k) % n);
         if (k < n && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/bank_arbiter_if.sv
// Request/grant bundle between a requester group and its round-robin arbiter.
interface bank_arbiter_if #(
   parameter int unsigned N = 2
);
   logic [N-1:0] req;
   logic [N-1:0] gnt;

   modport master (output req, input gnt);
   modport slave  (input req, output gnt);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req and a registered pointer.
module rr_arbiter
   import bank_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input logic           clk_i,
   input logic           rst_i,
   bank_arbiter_if.slave arb
);

   localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

   logic [PtrW-1:0]    ptr_q, ptr_d;
   logic [MAX_REQ-1:0] req_ext;
   logic [MAX_REQ-1:0] pick;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = arb.req;
      pick           = rr_pick(req_ext, 32'(ptr_q), N);
      // Grants are forced low while reset is held so nothing is accepted.
      arb.gnt = rst_i ? '0 : pick[N-1:0];
      ptr_d   = ptr_q;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (pick[i]) ptr_d = PtrW'((i + 1) % N);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/bank_arbiter.sv
// Independent read/write round-robin arbitration in front of a 1-cycle SRAM bank.
// Define BANK_ARB_BYPASS_EN to forward write data to a same-cycle same-address read.
module bank_arbiter
   import bank_pkg::*;
#(
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 2,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                       vsi_clk,
   input  logic                       vsi_reset,
   input  logic [NUM_WR-1:0]          wr_req,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   output logic [NUM_WR-1:0]          wr_gnt,
   input  logic [NUM_RD-1:0]          rd_req,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD-1:0]          rd_gnt,
   output logic                       rd_valid,
   output logic [$clog2(NUM_RD)-1:0]  rd_id,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       mem_wcs,
   output logic [ADDR_W-1:0]          mem_waddr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       mem_rcs,
   output logic [ADDR_W-1:0]          mem_raddr,
   input  logic [DATA_W-1:0]          mem_rdata
);

   localparam int unsigned RdIdW = $clog2(NUM_RD);

   bank_arbiter_if #(.N(NUM_WR)) wr_arb_if ();
   bank_arbiter_if #(.N(NUM_RD)) rd_arb_if ();

   assign wr_arb_if.req = wr_req;
   assign rd_arb_if.req = rd_req;
   assign wr_gnt        = wr_arb_if.gnt;
   assign rd_gnt        = rd_arb_if.gnt;

   rr_arbiter #(.N(NUM_WR)) u_wr_arb (
      .clk_i (vsi_clk),
      .rst_i (vsi_reset),
      .arb   (wr_arb_if)
   );

   rr_arbiter #(.N(NUM_RD)) u_rd_arb (
      .clk_i (vsi_clk),
      .rst_i (vsi_reset),
      .arb   (rd_arb_if)
   );

   logic [RdIdW-1:0] rd_idx;
   logic             rd_valid_q, rd_valid_d;
   logic [RdIdW-1:0] rd_id_q, rd_id_d;

   // Grants are one-hot, so a priority-free mux selects the granted slice.
   always_comb begin
      mem_waddr = '0;
      mem_wdata = '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         if (wr_gnt[i]) begin
            mem_waddr = wr_addr[i*ADDR_W +: ADDR_W];
            mem_wdata = wr_data[i*DATA_W +: DATA_W];
         end
      end
      mem_raddr = '0;
      rd_idx    = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         if (rd_gnt[i]) begin
            mem_raddr = rd_addr[i*ADDR_W +: ADDR_W];
            rd_idx    = RdIdW'(i);
         end
      end
   end

   assign mem_wcs    = |wr_gnt;
   assign mem_rcs    = |rd_gnt;
   assign rd_valid_d = mem_rcs;
   assign rd_id_d    = rd_idx;

   always_ff @(posedge vsi_clk or posedge vsi_reset) begin
      if (vsi_reset) begin
         rd_valid_q <= 1'b0;
         rd_id_q    <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_id_q    <= rd_id_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_id    = rd_id_q;

`ifdef BANK_ARB_BYPASS_EN
   logic              byp_hit_q, byp_hit_d;
   logic [DATA_W-1:0] byp_data_q, byp_data_d;

   assign byp_hit_d  = mem_wcs && mem_rcs && (mem_waddr == mem_raddr);
   assign byp_data_d = mem_wdata;

   always_ff @(posedge vsi_clk or posedge vsi_reset) begin
      if (vsi_reset) begin
         byp_hit_q  <= 1'b0;
         byp_data_q <= '0;
      end else begin
         byp_hit_q  <= byp_hit_d;
         byp_data_q <= byp_data_d;
      end
   end

   assign rd_data = !rd_valid_q ? '0 : (byp_hit_q ? byp_data_q : mem_rdata);
`else
   assign rd_data = rd_valid_q ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
// Randomised scoreboard bench for bank_arbiter with a behavioural SRAM and arbitration model.
module tb_bank_arbiter;

   localparam int NRD = 2;
   localparam int NWR = 2;
   localparam int AW  = 7;
   localparam int DW  = 128;

   logic             clk;
   logic             rst;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic [NRD*AW-1:0] rd_addr;
   logic             rd_valid;
   logic [$clog2(NRD)-1:0] rd_id;
   logic [DW-1:0]    rd_data;
   logic             mem_wcs, mem_rcs;
   logic [AW-1:0]    mem_waddr, mem_raddr;
   logic [DW-1:0]    mem_wdata, mem_rdata;

   bank_arbiter_if #(.N(NWR)) wr_bus ();
   bank_arbiter_if #(.N(NRD)) rd_bus ();

   bank_arbiter #(.NUM_RD(NRD), .NUM_WR(NWR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .vsi_clk   (clk),
      .vsi_reset (rst),
      .wr_req    (wr_bus.req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_gnt    (wr_bus.gnt),
      .rd_req    (rd_bus.req),
      .rd_addr   (rd_addr),
      .rd_gnt    (rd_bus.gnt),
      .rd_valid  (rd_valid),
      .rd_id     (rd_id),
      .rd_data   (rd_data),
      .mem_wcs   (mem_wcs),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_rcs   (mem_rcs),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata)
   );

   // Behavioural SRAM bank: registered read, write takes effect at the edge.
   logic [DW-1:0] sram [2**AW];
   always @(posedge clk) begin
      if (mem_wcs) sram[mem_waddr] <= mem_wdata;
      if (mem_rcs) mem_rdata <= sram[mem_raddr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [DW-1:0] mem_ref [2**AW];
   int            wptr, rptr;
   bit            w_pend [NWR];
   bit            r_pend [NRD];
   logic [AW-1:0] w_a [NWR];
   logic [DW-1:0] w_d [NWR];
   logic [AW-1:0] r_a [NRD];
   logic [NWR-1:0] last_wgnt;
   logic [NRD-1:0] last_rgnt;
   logic          last_wcs, last_rcs;

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
      bit            skip;
   } exp_t;
   exp_t exp_q[$];
   bit   run = 0;

   function automatic int pick(input int ptr, input logic [3:0] v, input int n);
      for (int k = 0; k < n; k++) begin
         int i;
         i = (ptr + k) % n;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic drive(input int pct);
      for (int i = 0; i < NWR; i++) begin
         if (!w_pend[i] && $urandom_range(99) < pct) begin
            w_pend[i] = 1'b1;
            w_a[i]    = AW'($urandom_range(15));
            w_d[i]    = {$urandom, $urandom, $urandom, $urandom};
         end
         wr_bus.req[i]          = w_pend[i];
         wr_addr[i*AW +: AW]    = w_a[i];
         wr_data[i*DW +: DW]    = w_d[i];
      end
      for (int i = 0; i < NRD; i++) begin
         if (!r_pend[i] && $urandom_range(99) < pct) begin
            r_pend[i] = 1'b1;
            r_a[i]    = AW'($urandom_range(15));
         end
         rd_bus.req[i]       = r_pend[i];
         rd_addr[i*AW +: AW] = r_a[i];
      end
   endtask

   task automatic check_update();
      logic [3:0]    wv, rv;
      int            w, r;
      logic [DW-1:0] ew, er;
      exp_t          e;
      wv = '0;
      rv = '0;
      for (int i = 0; i < NWR; i++) wv[i] = w_pend[i];
      for (int i = 0; i < NRD; i++) rv[i] = r_pend[i];
      w  = pick(wptr, wv, NWR);
      r  = pick(rptr, rv, NRD);
      ew = (w < 0) ? '0 : DW'(1) << w;
      er = (r < 0) ? '0 : DW'(1) << r;
      last_wgnt = wr_bus.gnt;
      last_rgnt = rd_bus.gnt;
      last_wcs  = mem_wcs;
      last_rcs  = mem_rcs;
      chk("wr_gnt", wr_bus.gnt, ew);
      chk("rd_gnt", rd_bus.gnt, er);
      chk("mem_wcs", mem_wcs, (w >= 0) ? 1 : 0);
      chk("mem_rcs", mem_rcs, (r >= 0) ? 1 : 0);
      if (w >= 0) begin
         chk("mem_waddr", mem_waddr, w_a[w]);
         chk("mem_wdata", mem_wdata, w_d[w]);
      end
      if (r >= 0) begin
         chk("mem_raddr", mem_raddr, r_a[r]);
         e.due  = cyc + 1;
         e.id   = r;
         e.data = mem_ref[r_a[r]];
         e.skip = 1'b0;
         if (w >= 0 && w_a[w] == r_a[r]) begin
`ifdef BANK_ARB_BYPASS_EN
            e.data = w_d[w];
`else
            e.skip = 1'b1;
`endif
         end
         exp_q.push_back(e);
         rptr      = (r + 1) % NRD;
         r_pend[r] = 1'b0;
      end
      if (w >= 0) begin
         mem_ref[w_a[w]] = w_d[w];
         wptr            = (w + 1) % NWR;
         w_pend[w]       = 1'b0;
      end
   endtask

   task automatic cycle(input int pct);
      drive(pct);
      @(negedge clk);
      check_update();
      @(posedge clk);
      #1;
   endtask

   // Read-return monitor
   always @(negedge clk) begin
      if (run && !rst) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rd_valid", rd_valid, 1);
            chk("rd_id", rd_id, e.id);
            if (!e.skip) chk("rd_data", rd_data, e.data);
         end else begin
            chk("rd_valid_idle", rd_valid, 0);
            chk("rd_data_idle", rd_data, 0);
         end
      end
   end

   initial begin
      logic [NWR-1:0] seq [4];
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
      rst = 1'b1;
      wptr = 0;
      rptr = 0;
      for (int i = 0; i < 2**AW; i++) begin
         sram[i]    = '0;
         mem_ref[i] = '0;
      end
      mem_rdata = '0;
      for (int i = 0; i < NWR; i++) begin
         w_pend[i] = 1'b1; w_a[i] = AW'(i + 1); w_d[i] = DW'(i + 7);
      end
      for (int i = 0; i < NRD; i++) begin
         r_pend[i] = 1'b1; r_a[i] = AW'(i + 1);
      end
      drive(0);
      #2;
      chk("rst_wr_gnt", wr_bus.gnt, 0);
      chk("rst_rd_gnt", rd_bus.gnt, 0);
      chk("rst_wcs", mem_wcs, 0);
      chk("rst_rcs", mem_rcs, 0);
      chk("rst_waddr", mem_waddr, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_id", rd_id, 0);
      chk("rst_rd_data", rd_data, 0);
      for (int i = 0; i < NRD; i++) r_pend[i] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      run = 1'b1;

      // Both writers held for four cycles: alternate starting at writer 0
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < NWR; i++) begin
            w_pend[i] = 1'b1; w_a[i] = AW'(16 + 2 * k + i); w_d[i] = DW'(100 + k);
         end
         cycle(0);
         chk("rr_seq", last_wgnt, seq[k]);
      end
      for (int i = 0; i < NWR; i++) w_pend[i] = 1'b0;

      // Read latency: writer 0 stores A5.. at 5, reader 1 reads it back
      w_pend[0] = 1'b1; w_a[0] = 7'h05; w_d[0] = {16{8'hA5}};
      cycle(0);
      r_pend[1] = 1'b1; r_a[1] = 7'h05;
      cycle(0);
      cycle(0);

      // Concurrent write (addr 3) and read (addr 9)
      w_pend[0] = 1'b1; w_a[0] = 7'h03; w_d[0] = DW'(32'hCAFE);
      r_pend[1] = 1'b1; r_a[1] = 7'h09;
      cycle(0);
      chk("conc_wcs", last_wcs, 1);
      chk("conc_rcs", last_rcs, 1);
      cycle(0);

      // Same-address collision
      w_pend[0] = 1'b1; w_a[0] = 7'h04; w_d[0] = DW'(1);
      r_pend[0] = 1'b1; r_a[0] = 7'h04;
      cycle(0);
      cycle(0);

      // Idle stretch; pointer retention shows up in the following grants
      repeat (10) cycle(0);
      repeat (400) cycle(35);
      repeat (4) cycle(0);

      // Reset asserted right after a read is granted: its return is dropped
      r_pend[0] = 1'b1; r_a[0] = 7'h05;
      drive(0);
      @(negedge clk);
      check_update();
      chk("midrst_rgnt", last_rgnt, 2'b01);
      rst = 1'b1;
      exp_q.delete();
      wptr = 0;
      rptr = 0;
      @(posedge clk);
      #1;
      chk("midrst_rd_valid", rd_valid, 0);
      chk("midrst_rd_data", rd_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < NWR; i++) begin
         w_pend[i] = 1'b1; w_a[i] = AW'(40 + i); w_d[i] = DW'(200 + i);
      end
      for (int i = 0; i < NRD; i++) begin
         r_pend[i] = 1'b1; r_a[i] = AW'(50 + i);
      end
      cycle(0);
      chk("post_rst_wgnt", last_wgnt, 2'b01);
      chk("post_rst_rgnt", last_rgnt, 2'b01);
      repeat (4) cycle(0);

      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL rd_return_missing: got %0d outstanding expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
